// File: rtl/group1_accum_adder.sv
// Handshaked a+b adder with pass-through or running add/subtract accumulator and one output register.
// Optional build macro ACC_SAT_EN: accumulate saturates on carry/borrow instead of wrapping.
module group1_accum_adder #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 acc_en,
    input  logic                 op_sub,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] count
);

`ifdef ACC_SAT_EN
    function automatic logic [ACC_WIDTH-1:0] resolve_acc(input logic [ACC_WIDTH:0] raw,
                                                         input logic sub);
        if (raw[ACC_WIDTH])
            return sub ? '0 : '1;
        return raw[ACC_WIDTH-1:0];
    endfunction
`else
    function automatic logic [ACC_WIDTH-1:0] resolve_acc(input logic [ACC_WIDTH:0] raw);
        return raw[ACC_WIDTH-1:0];
    endfunction
`endif

    logic                 vld_p1;
    logic [ACC_WIDTH-1:0] data_p1;
    logic [ACC_WIDTH-1:0] acc_p1;
    logic                 ovf_p1;
    logic [CNT_WIDTH-1:0] cnt_p1;

    logic                 accept;
    logic [ACC_WIDTH:0]   t_p0;
    logic [ACC_WIDTH:0]   acc_base_p0;
    logic [ACC_WIDTH:0]   raw_p0;
    logic                 flag_p0;
    logic                 ovf_base_p0;
    logic [CNT_WIDTH-1:0] cnt_base_p0;
    logic [ACC_WIDTH-1:0] nxt_p0;
    logic [ACC_WIDTH-1:0] result_p0;

    assign in_ready  = !rst && (!vld_p1 || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign overflow  = ovf_p1;
    assign count     = cnt_p1;

    // Stage p0: operand sum and accumulator update; clear is folded in ahead of the beat
    always_comb begin
        t_p0        = {{(ACC_WIDTH - WIDTH){1'b0}}, {1'b0, a} + {1'b0, b}};
        acc_base_p0 = clear ? '0 : {1'b0, acc_p1};
        ovf_base_p0 = !clear && ovf_p1;
        cnt_base_p0 = clear ? '0 : cnt_p1;
        raw_p0      = op_sub ? (acc_base_p0 - t_p0) : (acc_base_p0 + t_p0);
        // Top bit of the widened result is the carry (add) or borrow (subtract)
        flag_p0     = raw_p0[ACC_WIDTH];
`ifdef ACC_SAT_EN
        nxt_p0      = resolve_acc(raw_p0, op_sub);
`else
        nxt_p0      = resolve_acc(raw_p0);
`endif
        result_p0   = acc_en ? nxt_p0 : t_p0[ACC_WIDTH-1:0];
    end

    // Stage p1: registered output, accumulator, sticky flag and beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            acc_p1  <= '0;
            ovf_p1  <= 1'b0;
            cnt_p1  <= '0;
        end else begin
            if (accept) begin
                vld_p1  <= 1'b1;
                data_p1 <= result_p0;
            end else if (out_ready) begin
                vld_p1  <= 1'b0;
            end

            if (accept && acc_en) begin
                acc_p1 <= nxt_p0;
                ovf_p1 <= ovf_base_p0 | flag_p0;
            end else begin
                acc_p1 <= acc_base_p0[ACC_WIDTH-1:0];
                ovf_p1 <= ovf_base_p0;
            end

            if (accept)
                cnt_p1 <= cnt_base_p0 + CNT_WIDTH'(1);
            else
                cnt_p1 <= cnt_base_p0;
        end
    end

endmodule

// File: tb/tb_group1_accum_adder.sv
// Bench for group1_accum_adder: directed scenarios plus random traffic checked against an integer model.
module tb_group1_accum_adder;
    localparam int W    = 8;
    localparam int AW   = 16;
    localparam int CW   = 8;
    localparam int AMAX = 1 << AW;
    localparam int CMAX = 1 << CW;
`ifdef ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          acc_en;
    logic          op_sub;
    logic          clear;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic          overflow;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state in plain integers
    int m_acc  = 0;
    int m_ovf  = 0;
    int m_cnt  = 0;
    int m_vld  = 0;
    int m_data = 0;

    always #5 clk = ~clk;

    group1_accum_adder #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .acc_en(acc_en), .op_sub(op_sub), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .overflow(overflow), .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_ovf = 0; m_cnt = 0; m_vld = 0; m_data = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_vld));
        chk({tag, ".out_data"},  32'(out_data),  32'(m_data));
        chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        chk({tag, ".count"},     32'(count),     32'(m_cnt));
    endtask

    // One clock cycle: drive inputs, check in_ready, advance the model, check outputs after the edge
    task automatic cycle(input string tag, input bit iv, input int av, input int bv,
                         input bit en, input bit sub, input bit clr, input bit ordy);
        int  acc_t, t, s;
        bit  rdy;
        in_valid  = iv;
        a         = W'(av);
        b         = W'(bv);
        acc_en    = en;
        op_sub    = sub;
        clear     = clr;
        out_ready = ordy;
        #1;
        rdy = (m_vld == 0) || ordy;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));

        acc_t = clr ? 0 : m_acc;
        if (clr) begin
            m_ovf = 0;
            m_cnt = 0;
        end
        if (iv && rdy) begin
            t = av + bv;
            if (!en) begin
                m_data = t;
                m_acc  = acc_t;
            end else if (!sub) begin
                s = acc_t + t;
                if (s >= AMAX) begin
                    m_ovf = 1;
                    s = SAT ? AMAX - 1 : s - AMAX;
                end
                m_acc = s; m_data = s;
            end else begin
                if (t > acc_t) begin
                    m_ovf = 1;
                    s = SAT ? 0 : acc_t - t + AMAX;
                end else begin
                    s = acc_t - t;
                end
                m_acc = s; m_data = s;
            end
            m_vld = 1;
            m_cnt = (m_cnt + 1) % CMAX;
        end else begin
            m_acc = acc_t;
            if (ordy) m_vld = 0;
        end

        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; a = 0; b = 0; acc_en = 0; op_sub = 0; clear = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        check_state("rst");
        rst = 1'b0;

        // Pass-through
        cycle("pass", 1, 200, 100, 0, 0, 0, 1);
        chk("pass.const", 32'(out_data), 32'd300);

        // Three accumulating beats after a clear
        cycle("clr0", 0, 0, 0, 0, 0, 1, 1);
        cycle("acc1", 1, 255, 255, 1, 0, 0, 1);
        chk("acc1.const", 32'(out_data), 32'd510);
        cycle("acc2", 1, 255, 255, 1, 0, 0, 1);
        chk("acc2.const", 32'(out_data), 32'd1020);
        cycle("acc3", 1, 255, 255, 1, 0, 0, 1);
        chk("acc3.const", 32'(out_data), 32'd1530);
        chk("acc3.count", 32'(count), 32'd3);

        // Build acc=65000 then overflow on the top end
        cycle("clr1", 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 127; i++) cycle("build", 1, 255, 255, 1, 0, 0, 1);
        cycle("build_end", 1, 230, 0, 1, 0, 0, 1);
        chk("acc65000", 32'(out_data), 32'd65000);
        cycle("near_top", 1, 255, 255, 1, 0, 0, 1);
        cycle("carry", 1, 245, 245, 1, 0, 0, 1);
        chk("carry.const", 32'(out_data), SAT ? 32'd65535 : 32'd464);
        chk("carry.ovf", 32'(overflow), 32'd1);

        // Borrow: 10 - 20
        cycle("clr2", 0, 0, 0, 0, 0, 1, 1);
        cycle("ten", 1, 10, 0, 1, 0, 0, 1);
        cycle("borrow", 1, 20, 0, 1, 1, 0, 1);
        chk("borrow.const", 32'(out_data), SAT ? 32'd0 : 32'd65526);
        chk("borrow.ovf", 32'(overflow), 32'd1);

        // acc=500 with overflow still set, then clear together with a beat
        cycle("to500", 1, SAT ? 250 : 255, SAT ? 250 : 255, 1, 0, 0, 1);
        chk("to500.const", 32'(out_data), 32'd500);
        cycle("clr_acc", 1, 5, 6, 1, 0, 1, 1);
        chk("clr_acc.data", 32'(out_data), 32'd11);
        chk("clr_acc.ovf", 32'(overflow), 32'd0);
        chk("clr_acc.count", 32'(count), 32'd1);

        // Stall four cycles, then release
        for (int i = 0; i < 4; i++) cycle("stall", 1, 7 + i, 3, 1, i[0], 0, 0);
        chk("stall.data", 32'(out_data), 32'd11);
        for (int i = 0; i < 3; i++) cycle("release", 1, 1, 1, 1, 0, 0, 1);
        chk("release.count", 32'(count), 32'd4);

        // Random traffic
        for (int i = 0; i < 700; i++)
            cycle("rand", ($urandom % 4) != 0, int'($urandom % 256), int'($urandom % 256),
                  1'($urandom % 2), 1'($urandom % 2), ($urandom % 150) == 0, ($urandom % 4) != 0);

        // Reset asserted mid-stall
        cycle("pre_rst", 1, 9, 9, 1, 0, 0, 1);
        cycle("stall_rst", 1, 4, 4, 1, 0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst.in_ready", 32'(in_ready), 32'd0);
        check_state("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("post_rst", 1, 1, 2, 1, 0, 0, 1);
        chk("post_rst.const", 32'(out_data), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
